ppu_opsum_packer: RTL and testbench

Post-processing unit directly downstream of the PE array's opsum output. It consumes 32-bit signed partial sums over a valid/ready handshake and requantizes each one: arithmetic right shift with optional rounding, optional ReLU, then saturation to int8 and re-biasing to uint8 (XOR 0x80, matching the PE's ifmap convention). Four results are packed per 32-bit word for write-back to the global buffer. One configured tile of `cfg_count` results is processed per run.

---
 rtl/ppu_opsum_packer.sv | 174 +++++++++++++++++
 tb/tb_ppu_opsum_packer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_opsum_packer.sv
// ppu_opsum_packer: requantizes 32-bit signed opsums to uint8 and packs four per word.
// Optional macro PPU_ROUND_EN adds round-half-up bias before the arithmetic shift.
module ppu_opsum_packer #(
  parameter int DATA_BITS = 32,
  parameter int CNT_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
  input  logic [CNT_BITS-1:0]  cfg_count,
  input  logic [DATA_BITS-1:0] opsum,
  input  logic                 opsum_valid,
  output logic                 opsum_ready,
  output logic [DATA_BITS-1:0] packed_data,
  output logic [3:0]           packed_strb,
  output logic                 packed_last,
  output logic                 packed_valid,
  input  logic                 packed_ready,
  output logic                 busy
);

  localparam int W = DATA_BITS + 1;
  localparam logic signed [W-1:0] SAT_MAX = W'(127);
  localparam logic signed [W-1:0] SAT_MIN = -W'(128);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [4:0]           shift_q;
  logic                 relu_q;
  logic [CNT_BITS-1:0]  count_q;
  logic [CNT_BITS-1:0]  in_cnt;
  logic [1:0]           lane_cnt;
  logic [DATA_BITS-1:0] acc;

  logic                 start;
  logic                 accept;
  logic                 word_fire;
  logic                 final_beat;
  logic                 complete;
  logic signed [W-1:0]  x_ext;
  logic signed [W-1:0]  bias;
  logic signed [W-1:0]  sum;
  logic signed [W-1:0]  shifted;
  logic signed [W-1:0]  r;
  logic [7:0]           out_byte;
  logic [DATA_BITS-1:0] merged;
  logic [3:0]           fill_strb;

  assign start       = (state_q == IDLE) && cfg_en && (cfg_count != '0);
  assign opsum_ready = (state_q == RUN) && (!packed_valid || packed_ready);
  assign accept      = opsum_valid && opsum_ready;
  assign word_fire   = packed_valid && packed_ready;
  assign final_beat  = (in_cnt + CNT_BITS'(1)) == count_q;
  assign complete    = accept && ((lane_cnt == 2'd3) || final_beat);
  assign busy        = (state_q != IDLE);

  // Requantize in 33 bits so that the rounding bias can never overflow the opsum range.
  always_comb begin
    x_ext = {opsum[DATA_BITS-1], opsum};
    bias  = '0;
`ifdef PPU_ROUND_EN
    if (shift_q != 5'd0) begin
      bias = W'(1) << (shift_q - 5'd1);
    end
`endif
    sum     = x_ext + bias;
    shifted = sum >>> shift_q;
    r       = shifted;
    if (relu_q && shifted[W-1]) begin
      r = '0;
    end
    if (r > SAT_MAX) begin
      out_byte = 8'hFF;
    end else if (r < SAT_MIN) begin
      out_byte = 8'h00;
    end else begin
      out_byte = r[7:0] ^ 8'h80;
    end
  end

  always_comb begin
    merged    = acc | (DATA_BITS'(out_byte) << {lane_cnt, 3'b000});
    fill_strb = 4'b0001;
    case (lane_cnt)
      2'd0:    fill_strb = 4'b0001;
      2'd1:    fill_strb = 4'b0011;
      2'd2:    fill_strb = 4'b0111;
      default: fill_strb = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && final_beat) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (word_fire && packed_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      relu_q   <= 1'b0;
      count_q  <= '0;
      in_cnt   <= '0;
      lane_cnt <= '0;
      acc      <= '0;
    end else if (start) begin
      shift_q  <= cfg_shift;
      relu_q   <= cfg_relu;
      count_q  <= cfg_count;
      in_cnt   <= '0;
      lane_cnt <= '0;
      acc      <= '0;
    end else if (accept) begin
      in_cnt <= in_cnt + CNT_BITS'(1);
      if (complete) begin
        acc      <= '0;
        lane_cnt <= '0;
      end else begin
        acc      <= merged;
        lane_cnt <= lane_cnt + 2'd1;
      end
    end
  end

  // A completing beat may reload the output register in the same cycle the old word leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packed_data  <= '0;
      packed_strb  <= '0;
      packed_last  <= 1'b0;
      packed_valid <= 1'b0;
    end else if (complete) begin
      packed_data  <= merged;
      packed_strb  <= fill_strb;
      packed_last  <= final_beat;
      packed_valid <= 1'b1;
    end else if (word_fire) begin
      packed_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_opsum_packer.sv
// Self-checking bench for ppu_opsum_packer: byte-level model plus word scoreboard and literal checks.
module tb_ppu_opsum_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [9:0]  cfg_count;
  logic [31:0] opsum;
  logic        opsum_valid;
  logic        opsum_ready;
  logic [31:0] packed_data;
  logic [3:0]  packed_strb;
  logic        packed_last;
  logic        packed_valid;
  logic        packed_ready;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] tile_vals[$];
  int          vectors = 0;
  int          miscompares = 0;

  logic        hold_pending = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_strb;
  logic        held_last;

  ppu_opsum_packer #(.DATA_BITS(32), .CNT_BITS(10)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_en(cfg_en),
    .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu),
    .cfg_count(cfg_count),
    .opsum(opsum),
    .opsum_valid(opsum_valid),
    .opsum_ready(opsum_ready),
    .packed_data(packed_data),
    .packed_strb(packed_strb),
    .packed_last(packed_last),
    .packed_valid(packed_valid),
    .packed_ready(packed_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Requantization as plain integer arithmetic; uint8 re-bias expressed as +128.
  function automatic logic [7:0] quant(input int x, input int sh, input bit relu);
    longint v;
    longint res;
    v = longint'(x);
`ifdef PPU_ROUND_EN
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
    res = v >>> sh;
    if (relu && res < 0) res = 0;
    if (res > 127) res = 127;
    if (res < -128) res = -128;
    return 8'(res + 128);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Builds the expected word stream for tile_vals and queues it for the compare process.
  task automatic model_push(input int sh, input bit relu);
    word_t w;
    int    lane;
    w = '{data: 32'h0, strb: 4'h0, last: 1'b0};
    for (int i = 0; i < tile_vals.size(); i++) begin
      lane   = i % 4;
      w.data = w.data | (32'(quant($signed(tile_vals[i]), sh, relu)) << (8 * lane));
      w.strb = w.strb | 4'(1 << lane);
      if (lane == 3 || i == tile_vals.size() - 1) begin
        w.last = (i == tile_vals.size() - 1);
        exp_q.push_back(w);
        w = '{data: 32'h0, strb: 4'h0, last: 1'b0};
      end
    end
  endtask

  task automatic configure(input int cnt, input int sh, input bit relu);
    cfg_count = 10'(cnt);
    cfg_shift = 5'(sh);
    cfg_relu  = relu;
    cfg_en    = 1'b1;
    step();
    cfg_en    = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] x);
    bit ok;
    int cycles;
    opsum       = x;
    opsum_valid = 1'b1;
    ok          = 1'b0;
    cycles      = 0;
    while (!ok && cycles < 100) begin
      @(negedge clk);
      ok = opsum_ready;
      step();
      cycles++;
    end
    opsum_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: opsum 0x%0h not accepted in 100 cycles", x);
    end
  endtask

  task automatic wait_word(input string name, input logic [31:0] d, input logic [3:0] s, input logic l);
    int cycles;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!packed_valid && cycles < 50);
    check_output({name, "_valid"}, 32'(packed_valid), 32'h1);
    check_output({name, "_data"}, packed_data, d);
    check_output({name, "_strb"}, 32'(packed_strb), 32'(s));
    check_output({name, "_last"}, 32'(packed_last), 32'(l));
  endtask

  task automatic single_beat(input string name, input logic [31:0] x, input int sh, input bit relu,
                             input logic [7:0] exp_byte);
    configure(1, sh, relu);
    tile_vals = '{x};
    model_push(sh, relu);
    apply_stimulus(x);
    wait_word(name, {24'h0, exp_byte}, 4'b0001, 1'b1);
    step();
  endtask

  // Scoreboard on every word handshake, plus stability of a stalled word.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        vectors++;
        if (!packed_valid || packed_data !== held_data || packed_strb !== held_strb ||
            packed_last !== held_last) begin
          miscompares++;
          $display("[TB] FAIL stall_stable: got v=%0b d=0x%0h s=0x%0h l=%0b, held d=0x%0h s=0x%0h l=%0b",
                   packed_valid, packed_data, packed_strb, packed_last, held_data, held_strb, held_last);
        end
      end
      if (packed_valid && packed_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_word: got 0x%0h with no word expected", packed_data);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          if (packed_data !== e.data || packed_strb !== e.strb || packed_last !== e.last) begin
            miscompares++;
            $display("[TB] FAIL word: got d=0x%0h s=0x%0h l=%0b, expected d=0x%0h s=0x%0h l=%0b",
                     packed_data, packed_strb, packed_last, e.data, e.strb, e.last);
          end
        end
      end
      hold_pending = packed_valid && !packed_ready;
      held_data    = packed_data;
      held_strb    = packed_strb;
      held_last    = packed_last;
    end
  end

  initial begin
    rst          = 1'b1;
    cfg_en       = 1'b0;
    cfg_shift    = 5'd0;
    cfg_relu     = 1'b0;
    cfg_count    = 10'd0;
    opsum        = 32'h0;
    opsum_valid  = 1'b0;
    packed_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_output("rst_data", packed_data, 32'h0);
    check_output("rst_strb", 32'(packed_strb), 32'h0);
    check_output("rst_last", 32'(packed_last), 32'h0);
    check_output("rst_valid", 32'(packed_valid), 32'h0);
    check_output("rst_ready", 32'(opsum_ready), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b0;
    step();

    // Basic pack of one full word; IDLE two cycles after the 4th accept.
    configure(4, 0, 1'b0);
    check_output("busy_run", 32'(busy), 32'h1);
    tile_vals = '{32'd0, 32'd1, 32'd2, 32'd3};
    model_push(0, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(tile_vals[i]);
    wait_word("pack", 32'h83828180, 4'hF, 1'b1);
    check_output("pack_busy_hold", 32'(busy), 32'h1);
    @(negedge clk);
    check_output("pack_idle", 32'(busy), 32'h0);
    step();

    // Requantization corner cases, one single-beat tile each.
    single_beat("q300", 32'd300, 2, 1'b0, 8'hCB);
`ifdef PPU_ROUND_EN
    single_beat("q302", 32'd302, 2, 1'b0, 8'hCC);
    single_beat("qm6", -32'sd6, 2, 1'b0, 8'h7F);
`else
    single_beat("q302", 32'd302, 2, 1'b0, 8'hCB);
    single_beat("q303", 32'd303, 2, 1'b0, 8'hCB);
    single_beat("qm6", -32'sd6, 2, 1'b0, 8'h7E);
`endif
    single_beat("sat_hi", 32'd200, 0, 1'b0, 8'hFF);
    single_beat("sat_lo", -32'sd1000, 0, 1'b0, 8'h00);
    single_beat("sat_max", 32'h7FFFFFFF, 1, 1'b0, 8'hFF);
    single_beat("relu", -32'sd5, 0, 1'b1, 8'h80);
    single_beat("norelu", -32'sd5, 0, 1'b0, 8'h7B);

    // Partial tail; a cfg_en pulse mid-run must be ignored.
    configure(6, 0, 1'b0);
    tile_vals = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    model_push(0, 1'b0);
    apply_stimulus(32'd0);
    apply_stimulus(32'd1);
    configure(1, 3, 1'b1);
    apply_stimulus(32'd2);
    apply_stimulus(32'd3);
    wait_word("tail_w0", 32'h83828180, 4'hF, 1'b0);
    step();
    apply_stimulus(32'd4);
    apply_stimulus(32'd5);
    wait_word("tail_w1", 32'h00008584, 4'b0011, 1'b1);
    step();
    step();

    // Backpressure: stalled word blocks input; release handshakes and accepts together.
    configure(8, 0, 1'b0);
    tile_vals.delete();
    for (int i = 10; i < 18; i++) tile_vals.push_back(32'(i));
    model_push(0, 1'b0);
    packed_ready = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(tile_vals[i]);
    opsum       = tile_vals[4];
    opsum_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_output("bp_ready_low", 32'(opsum_ready), 32'h0);
    end
    check_output("bp_word", packed_data, 32'h8D8C8B8A);
    step();
    packed_ready = 1'b1;
    @(negedge clk);
    check_output("bp_release_ready", 32'(opsum_ready), 32'h1);
    check_output("bp_release_valid", 32'(packed_valid), 32'h1);
    step();
    for (int i = 5; i < 8; i++) apply_stimulus(tile_vals[i]);
    wait_word("bp_w1", 32'h91908F8E, 4'hF, 1'b1);
    step();
    step();

    // Reset mid-run discards the partial word.
    configure(4, 0, 1'b0);
    apply_stimulus(32'd7);
    apply_stimulus(32'd8);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_valid", 32'(packed_valid), 32'h0);
    check_output("mid_rst_ready", 32'(opsum_ready), 32'h0);
    check_output("mid_rst_busy", 32'(busy), 32'h0);
    check_output("mid_rst_data", packed_data, 32'h0);
    check_output("mid_rst_strb", 32'(packed_strb), 32'h0);
    step();
    rst = 1'b0;
    repeat (5) step();
    check_output("mid_rst_no_word", 32'(packed_valid), 32'h0);

    // Zero-length tile is ignored.
    configure(0, 0, 1'b0);
    check_output("cnt0_busy", 32'(busy), 32'h0);
    check_output("cnt0_ready", 32'(opsum_ready), 32'h0);
    repeat (3) step();

    check_output("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
